// File: rtl/gray_updown_counter.sv
// gray_updown_counter: parameterised up/down counter that exposes its count
// in Gray code and plain binary, both registered together. Supports loading
// a Gray-coded value, a one-cycle wrap pulse, a small direction/status FSM
// and a sticky flag that latches if successive Gray outputs ever jump by
// more than one bit outside a load.
module gray_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,        // synchronous, active-low
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic [1:0]       state,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] gray_reg, gray_next;
    logic             tc_reg, tc_next;
    logic             err_reg, err_next;
    state_t           state_reg, state_next;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] gray_diff;
    logic             multi_bit_step;

    // Gray-to-binary decode of the load value: each binary bit is the XOR of
    // all Gray bits at or above it. Written as a reduction per bit so there is
    // no chained dependency through load_bin itself.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign load_bin[gi] = ^load_gray[WIDTH-1:gi];
        end
    endgenerate

    // Next binary count, wrap pulse and status; load beats count beats hold.
    always_comb begin
        cnt_next   = cnt_reg;
        tc_next    = 1'b0;
        state_next = state_reg;
        if (load) begin
            cnt_next   = load_bin;
            state_next = ST_HOLD;
        end else if (en) begin
            if (up_dn) begin
                cnt_next   = cnt_reg + ONE;
                tc_next    = (cnt_reg == ALL_ONES);
                state_next = ST_UP;
            end else begin
                cnt_next   = cnt_reg - ONE;
                tc_next    = (cnt_reg == ZERO);
                state_next = ST_DOWN;
            end
        end else if (state_reg != ST_IDLE) begin
            state_next = ST_HOLD;
        end
    end

    // Gray encode of the next count so Gray and binary register on the same edge.
    always_comb begin
        gray_next = cnt_next ^ (cnt_next >> 1);
    end

    // Adjacency self-check: more than one set bit in the Gray delta is a
    // violation unless the update came from a load.
    always_comb begin
        gray_diff      = gray_reg ^ gray_next;
        multi_bit_step = |(gray_diff & (gray_diff - ONE));
        err_next       = err_reg | (multi_bit_step & ~load);
    end

    // Count registers: binary and Gray updated together.
    always_ff @(posedge clk) begin
        if (!res) begin
            cnt_reg  <= ZERO;
            gray_reg <= ZERO;
        end else begin
            cnt_reg  <= cnt_next;
            gray_reg <= gray_next;
        end
    end

    // Wrap pulse register; reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (!res) begin
            tc_reg <= 1'b0;
        end else begin
            tc_reg <= tc_next;
        end
    end

    // Status FSM state register.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sticky adjacency error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign gray_out = gray_reg;
    assign bin_out  = cnt_reg;
    assign tc       = tc_reg;
    assign state    = state_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Testbench for gray_updown_counter: directed scenarios from the test plan
// followed by randomized traffic compared against a table-driven model.
module tb_gray_updown_counter;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_gray = '0;
    logic [W-1:0] gray_out;
    logic [W-1:0] bin_out;
    logic         tc;
    logic [1:0]   state;
    logic         err;

    int errors = 0;
    int checks = 0;

    // Reference model: count as an integer index into a Gray table built by
    // reflection, status as an integer code.
    int gtab[N];
    int m_cnt = 0;
    int m_tc = 0;
    int m_err = 0;
    int m_state = 0;

    gray_updown_counter #(.WIDTH(W)) dut (
        .clk(clk), .res(res), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .gray_out(gray_out), .bin_out(bin_out),
        .tc(tc), .state(state), .err(err)
    );

    always #25 clk = ~clk;

    function automatic void build_table();
        gtab[0] = 0;
        for (int k = 0; k < W; k++) begin
            int size = 1 << k;
            for (int i = 0; i < size; i++)
                gtab[size + i] = size | gtab[size - 1 - i];
        end
    endfunction

    function automatic int index_of_gray(int g);
        int idx = 0;
        for (int i = 0; i < N; i++)
            if (gtab[i] == g) idx = i;
        return idx;
    endfunction

    // Advance one edge and update the model from the inputs seen at that edge.
    task automatic clk_step();
        int prev;
        @(posedge clk);
        #1;
        prev = m_cnt;
        if (!res) begin
            m_cnt = 0; m_tc = 0; m_err = 0; m_state = 0;
        end else if (load) begin
            m_cnt = index_of_gray(int'(load_gray));
            m_tc = 0; m_state = 3;
        end else if (en) begin
            if (up_dn) begin
                m_tc = (m_cnt == N - 1) ? 1 : 0;
                m_cnt = (m_cnt + 1) % N;
                m_state = 1;
            end else begin
                m_tc = (m_cnt == 0) ? 1 : 0;
                m_cnt = (m_cnt + N - 1) % N;
                m_state = 2;
            end
        end else begin
            m_tc = 0;
            if (m_state != 0) m_state = 3;
        end
        if (res && !load && $countones(gtab[prev] ^ gtab[m_cnt]) > 1) m_err = 1;
    endtask

    task automatic test_reset();
        res = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            checks++;
            if (gray_out !== 4'b0000 || bin_out !== 4'b0000 || tc !== 1'b0 || err !== 1'b0 || state !== 2'd0) begin
                errors++;
                $display("FAIL reset edge %0d: gray=%b bin=%b tc=%b err=%b state=%0d, required 0000 0000 0 0 0",
                         i, gray_out, bin_out, tc, err, state);
            end
        end
        // With nothing requested, IDLE must persist after reset release.
        res = 1'b1; en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            checks++;
            if (state !== 2'd0 || gray_out !== 4'b0000) begin
                errors++;
                $display("FAIL idle_stays edge %0d: state=%0d gray=%b, required 0 0000", i, state, gray_out);
            end
        end
    endtask

    task automatic test_up_sweep();
        logic [W-1:0] exp_seq[16];
        exp_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                    4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        res = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            clk_step();
            checks++;
            if (gray_out !== exp_seq[i] || tc !== (i == 15) || state !== 2'd1 || err !== 1'b0
                || bin_out !== W'((i + 1) % N)) begin
                errors++;
                $display("FAIL up_sweep step %0d: gray=%b bin=%b tc=%b state=%0d err=%b, required gray=%b bin=%0d tc=%0d state=1 err=0",
                         i, gray_out, bin_out, tc, state, err, exp_seq[i], (i + 1) % N, (i == 15));
            end
        end
    endtask

    task automatic test_down_wrap();
        en = 1'b1; up_dn = 1'b0; load = 1'b0;
        clk_step();
        checks++;
        if (gray_out !== 4'b1000 || bin_out !== 4'b1111 || tc !== 1'b1 || state !== 2'd2) begin
            errors++;
            $display("FAIL down_wrap: gray=%b bin=%b tc=%b state=%0d, required 1000 1111 1 2", gray_out, bin_out, tc, state);
        end
        clk_step();
        checks++;
        if (gray_out !== 4'b1001 || tc !== 1'b0) begin
            errors++;
            $display("FAIL down_after_wrap: gray=%b tc=%b, required 1001 0", gray_out, tc);
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_gray = 4'b1101; en = 1'b1; up_dn = 1'b1;
        clk_step();
        checks++;
        if (gray_out !== 4'b1101 || bin_out !== 4'b1001 || state !== 2'd3 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load: gray=%b bin=%b state=%0d tc=%b, required 1101 1001 3 0", gray_out, bin_out, state, tc);
        end
        load = 1'b0;
        clk_step();
        checks++;
        if (gray_out !== 4'b1111 || bin_out !== 4'b1010 || state !== 2'd1) begin
            errors++;
            $display("FAIL load_then_up: gray=%b bin=%b state=%0d, required 1111 1010 1", gray_out, bin_out, state);
        end
        // Loading all-ones binary (Gray 1000) must not pulse tc.
        load = 1'b1; load_gray = 4'b1000;
        clk_step();
        checks++;
        if (tc !== 1'b0 || bin_out !== 4'b1111) begin
            errors++;
            $display("FAIL load_no_tc: tc=%b bin=%b, required 0 1111", tc, bin_out);
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_gray = 4'b0101; en = 1'b0;
        clk_step();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        clk_step();
        checks++;
        if (bin_out !== 4'b0111 || gray_out !== 4'b0100) begin
            errors++;
            $display("FAIL pre_reset: bin=%b gray=%b, required 0111 0100", bin_out, gray_out);
        end
        res = 1'b0;
        clk_step();
        checks++;
        if (gray_out !== 4'b0000 || bin_out !== 4'b0000 || tc !== 1'b0 || err !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: gray=%b bin=%b tc=%b err=%b state=%0d, required 0000 0000 0 0 0",
                     gray_out, bin_out, tc, err, state);
        end
        res = 1'b1;
        clk_step();
        checks++;
        if (gray_out !== 4'b0001 || tc !== 1'b0 || state !== 2'd1) begin
            errors++;
            $display("FAIL after_reset_up: gray=%b tc=%b state=%0d, required 0001 0 1", gray_out, tc, state);
        end
    endtask

    task automatic test_hold_reversal();
        load = 1'b1; load_gray = 4'b0110; en = 1'b0;
        clk_step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++;
            if (gray_out !== 4'b0110 || state !== 2'd3 || err !== 1'b0) begin
                errors++;
                $display("FAIL hold edge %0d: gray=%b state=%0d err=%b, required 0110 3 0", i, gray_out, state, err);
            end
        end
        en = 1'b1; up_dn = 1'b1;
        clk_step();
        checks++;
        if (gray_out !== 4'b0111 || state !== 2'd1) begin
            errors++;
            $display("FAIL reverse_up: gray=%b state=%0d, required 0111 1", gray_out, state);
        end
        up_dn = 1'b0;
        clk_step();
        checks++;
        if (gray_out !== 4'b0110 || state !== 2'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL reverse_down: gray=%b state=%0d err=%b, required 0110 2 0", gray_out, state, err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            res       = ($urandom_range(31) != 0);
            load      = ($urandom_range(7) == 0);
            en        = ($urandom_range(3) != 0);
            up_dn     = $urandom_range(1);
            load_gray = W'($urandom_range(N - 1));
            clk_step();
            checks++;
            if (gray_out !== W'(gtab[m_cnt]) || bin_out !== W'(m_cnt) || tc !== m_tc[0]
                || state !== 2'(m_state) || err !== m_err[0]) begin
                errors++;
                $display("FAIL random cycle %0d: gray=%b bin=%b tc=%b state=%0d err=%b, required gray=%b bin=%0d tc=%0d state=%0d err=%0d",
                         i, gray_out, bin_out, tc, state, err, W'(gtab[m_cnt]), m_cnt, m_tc, m_state, m_err);
            end
        end
    endtask

    initial begin
        build_table();
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_load();
        test_reset_mid();
        test_hold_reversal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_updown_counter.md
# gray_updown_counter

- Parameterised up/down Gray-code counter for the Flip-Flop & Counter group.
- Driven directly by the bench's clock/reset generator: 50 ns period, `res` pulsed after 100 ns.
- Provides:
  - a registered Gray-code count and its binary equivalent;
  - load of a Gray-coded value, with an internal Gray-to-binary decoder;
  - a wrap (terminal-count) pulse and a small direction/status state machine;
  - a sticky self-check flag that trips if consecutive Gray outputs ever differ in more than one bit outside a load.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- clk  in  1  single clock; all state updates on rising edge
- res  in  1  reset, synchronous, active-low; sampled on rising edge of clk
- en  in  1  count enable
- up_dn  in  1  direction when counting: 1 = up, 0 = down
- load  in  1  load request; higher priority than en
- load_gray  in  WIDTH  value to load, Gray-coded
- gray_out  out  WIDTH  registered Gray-code count
- bin_out  out  WIDTH  registered binary count (equals decode of gray_out)
- tc  out  1  one-cycle pulse on a wrap
- state  out  2  status: 0 IDLE, 1 UP, 2 DOWN, 3 HOLD
- err  out  1  sticky Gray-adjacency violation flag

## Operation
- Internal binary register `cnt`.
  - gray_out = cnt ^ (cnt >> 1).
  - bin_out = cnt.
  - Both are registered together; never one cycle apart.
- Priority per edge: res low > load > en > hold.
- **Reset** (res==0 at edge): cnt=0, gray_out=0, bin_out=0, tc=0, err=0, state=IDLE.
- **Load:**
  - cnt ← Gray-to-binary(load_gray): b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
  - state ← HOLD; tc=0; en and up_dn are ignored that cycle.
- **Count up** (en=1, up_dn=1): cnt ← cnt+1 mod 2^WIDTH; state ← UP.
- **Count down** (en=1, up_dn=0): cnt ← cnt−1 mod 2^WIDTH; state ← DOWN.
- **en=0, load=0:**
  - cnt unchanged.
  - state ← HOLD, except that IDLE stays IDLE.
  - IDLE is left only by a load or an enabled count.
- **tc** = 1 for exactly the cycle in which the registered count has just wrapped; otherwise 0.
  - Up wrap: all-ones → 0.
  - Down wrap: 0 → all-ones.
  - A load never asserts tc, even when it loads 0 or all-ones.
- **err:** set when the new gray_out differs from the previous gray_out in more than one bit and the update was not a load.
  - Hold (0 bits changed) and count (1 bit changed) never set it.
  - Once set, it stays set until reset.
- Direction may change on any cycle. Reversal steps back to the previous code, with one bit changed.

## Timing
- Latency: 1 clock. Inputs sampled at edge N appear on every output after edge N.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset is synchronous:
  - asserting res with no clk edge has no effect;
  - res must be low for ≥1 rising edge;
  - outputs hold reset values on every edge while res is low;
  - a count or load on the first edge after res returns high is honoured.
- Reset mid-count overrides en/load on the same edge. No tc is generated by the reset return to 0.
- Simultaneous load and en: load wins; the count resumes on the next edge from the loaded value.
- Bench clock is 50 ns period (toggle every 25 ns); there are no timing requirements beyond single-clock synchronous design.

## Test plan
1. **Reset:** res=0 for 2 edges, en=1 → gray_out=0000, bin_out=0000, tc=0, err=0, state=0 (IDLE); en ignored.
2. **Up sweep:** res=1, en=1, up_dn=1 for 16 edges →
   - gray_out goes 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000;
   - tc=1 only on the edge showing 0000;
   - state=1; err=0 throughout.
3. **Down wrap:** from count 0, en=1, up_dn=0 → gray_out=1000, bin_out=1111, tc=1, state=2; next edge gray_out=1001, tc=0.
4. **Load:** load=1, load_gray=1101, en=1 simultaneously → gray_out=1101, bin_out=1001, state=3, tc=0; next edge, up → gray_out=1111, bin_out=1010.
5. **Reset mid-operation:** counting up at bin_out=0111, drive res=0 with en=1 for one edge → all outputs zero, state=0, no tc; release → first up edge gives gray_out=0001.
6. **Hold and reversal:**
   - at 0110, en=0 for 3 edges → value held, state=3, err=0;
   - then up one (gray_out=0111) and down one → gray_out back to 0110;
   - err stays 0.
